// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and game constants for the Mastermind sequencer
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_GUESS = 3'd2,
    ST_SCORE = 3'd3,
    ST_WRITE = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_e;

  localparam int PEGS      = 4;
  localparam int COLOR_W   = 3;
  localparam int MAX_TURNS = 8;
  localparam int ALL_EXACT = 4;
  localparam int END_HOLD  = 5;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-cycle pulse on the rising edge of a debounced button level
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - Mastermind game-flow FSM: code latch, submit/score handshake,
// history write, win/lose detection and timed end-of-game hold.
module game_sequencer #(
  parameter int MAX_TURNS = game_pkg::MAX_TURNS,
  parameter int COLOR_W   = game_pkg::COLOR_W,
  parameter int END_HOLD  = game_pkg::END_HOLD
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sec_tick,
  input  logic                                   btn_select,
  input  logic                                   mode_sw,
  input  logic [game_pkg::PEGS*COLOR_W-1:0]      code_in,
  input  logic [game_pkg::PEGS*COLOR_W-1:0]      guess_in,
  input  logic                                   score_valid,
  input  logic [2:0]                             exact_cnt,
  input  logic [2:0]                             partial_cnt,
  output logic [game_pkg::PEGS*COLOR_W-1:0]      code_latched,
  output logic                                   score_req,
  output logic [game_pkg::PEGS*COLOR_W-1:0]      score_guess,
  output logic                                   hist_we,
  output logic [2:0]                             hist_addr,
  output logic [game_pkg::PEGS*COLOR_W+5:0]      hist_data,
  output logic [3:0]                             turn_count,
  output logic                                   guess_enable,
  output logic                                   win,
  output logic                                   lose,
  output logic                                   game_over
);

  import game_pkg::*;

  localparam int CODE_W = PEGS * COLOR_W;
  localparam int HOLD_W = (END_HOLD < 2) ? 1 : $clog2(END_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD - 1);

  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   guess_q;
  logic [2:0]          exact_q;
  logic [2:0]          partial_q;
  logic [3:0]          turn_q;
  logic [2:0]          addr_q;
  logic                req_q;
  logic                we_q;
  logic                ge_q;
  logic                win_q;
  logic                lose_q;
  logic                over_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic [3:0]          turn_d;
  logic                sel_rise;
  logic                end_exit;

  rise_detect u_sel_rise (
    .clk   (clk),
    .reset (reset),
    .level (btn_select),
    .pulse (sel_rise)
  );

  assign hold_d   = hold_q + (sec_tick ? HOLD_W'(1) : HOLD_W'(0));
  // A tick and a skip press landing together still produce a single exit.
  assign end_exit = sel_rise | (sec_tick & (hold_q == HOLD_LAST));
  assign turn_d   = turn_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      guess_q   <= '0;
      exact_q   <= '0;
      partial_q <= '0;
      turn_q    <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      ge_q      <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      over_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      we_q   <= 1'b0;
      over_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_rise) state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          code_q  <= code_in;
          turn_q  <= '0;
          ge_q    <= ~mode_sw;
          state_q <= ST_GUESS;
        end
        ST_GUESS: begin
          ge_q <= ~mode_sw;
          if (sel_rise && !mode_sw) begin
            guess_q <= guess_in;
            req_q   <= 1'b1;
            ge_q    <= 1'b0;
            state_q <= ST_SCORE;
          end
        end
        ST_SCORE: begin
          if (score_valid) begin
            exact_q   <= exact_cnt;
            partial_q <= partial_cnt;
            req_q     <= 1'b0;
            we_q      <= 1'b1;
            addr_q    <= turn_q[2:0];
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          turn_q <= turn_d;
          if (exact_q == 3'(ALL_EXACT)) begin
            win_q   <= 1'b1;
            state_q <= ST_WIN;
          end else if (turn_d == 4'(MAX_TURNS)) begin
            lose_q  <= 1'b1;
            state_q <= ST_LOSE;
          end else begin
            ge_q    <= ~mode_sw;
            state_q <= ST_GUESS;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (end_exit) begin
            over_q  <= 1'b1;
            hold_q  <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign code_latched = code_q;
  assign score_req    = req_q;
  assign score_guess  = guess_q;
  assign hist_we      = we_q;
  assign hist_addr    = addr_q;
  assign hist_data    = {guess_q, exact_q, partial_q};
  assign turn_count   = turn_q;
  assign guess_enable = ge_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign game_over    = over_q;

endmodule
